rsp_s1_op_sched: RTL and testbench
==================================

// Module: rsp_s1_op_sched
// PURPOSE
//  Command/op scheduler in front of the rsp_s1 prep engine. Accepts one command, then
//  round-robin arbitrates the op start requests of up to OP_NUM masters. For each granted
//  job it secures L1 banks (mem req/ack), launches the engine and waits for done.
//  It then returns a finish handshake to the granted op. All logic is on the engine clock.
// PARAMETERS
//  OP_NUM     16  number of op requesters
//  BANK_NUM   8   L1 bank-mask width
//  CMD_W      32  command info width, passed through to engine
//  START_W    32  per-op start info width
//  TMO_W      16  width of mem-ack timeout counter; timeout = 2**TMO_W-1 cycles
// PORTS
//  clk               in   1                  engine clock
//  reset             in   1                  synchronous, active-high reset
//  i_cmd_req         in   1                  command request, held until o_cmd_ack
//  i_cmd_info        in   CMD_W              command info, sampled with ack
//  i_cmd_cnt         in   8                  number of op jobs in this command
//  o_cmd_ack         out  1                  1-cycle command accept pulse
//  i_start_req_op    in   OP_NUM             per-op start request, held until own ack
//  i_start_info_op   in   OP_NUM*START_W     per-op start info, flat, op0 at LSBs
//  i_start_bm_op     in   OP_NUM*BANK_NUM    per-op bank mask, flat
//  o_start_ack_op    out  OP_NUM             one-hot 1-cycle start ack
//  o_mem_req         out  1                  bank request, held until i_mem_ack
//  o_mem_bm          out  BANK_NUM           bank mask of granted op, stable while o_mem_req
//  i_mem_ack         in   1                  bank grant
//  o_eng_start       out  1                  1-cycle engine launch pulse
//  o_eng_cmd_info    out  CMD_W              latched command info
//  o_eng_start_info  out  START_W            latched start info of granted op
//  o_eng_op_idx      out  $clog2(OP_NUM)     granted op index
//  i_eng_done        in   1                  1-cycle engine completion pulse
//  o_finish_req      out  1                  finish request, held until ack
//  o_finish_op_idx   out  $clog2(OP_NUM)     op being finished
//  i_finish_ack_op   in   OP_NUM             per-op finish ack
//  i_stop            in   1                  synchronous abort
//  o_busy            out  1                  state != IDLE
//  o_err_tmo         out  1                  sticky mem-ack timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; RR pointer=0; job counter=0; o_err_tmo=0.
//  FSM: IDLE, ARB, MEM, START, RUN, FIN.
//  - IDLE: i_cmd_req=1 -> o_cmd_ack=1 next cycle; latch cmd_info and cnt; clear o_err_tmo.
//    Go to ARB, or stay IDLE if cnt=0. Ack is still given when cnt=0.
//  - ARB: grant the lowest set i_start_req_op index >= ptr, wrapping modulo OP_NUM.
//    Stay in ARB while no request is set. On grant, latch idx/info/bm and go to MEM.
//  - MEM: o_mem_req=1, o_mem_bm=bm. i_mem_ack -> START and drop o_mem_req the same edge.
//    The timeout counter starts at 0 on MEM entry. At 2**TMO_W-1 with no ack:
//    set o_err_tmo, drop the request, go to IDLE; no start ack is given.
//  - START: one cycle; o_eng_start=1 and o_start_ack_op[idx]=1 together.
//    ptr <= (idx+1) mod OP_NUM. -> RUN.
//  - RUN: i_eng_done -> FIN. i_eng_done in any other state is ignored.
//  - FIN: o_finish_req=1, o_finish_op_idx=idx. Exit only on i_finish_ack_op[idx].
//    Acks on other bits are ignored. Increment job count; count==cnt -> IDLE, else -> ARB.
//  - Latency: cmd_req to cmd_ack 1 cycle. mem_ack to eng_start 1 cycle.
//    done to finish_req 1 cycle. finish ack to next ARB decision 1 cycle.
//  - i_stop=1 in a non-IDLE state: next state is IDLE and all reqs/pulses are 0 next cycle.
//    No acks are generated. ptr and o_err_tmo are kept. i_stop in IDLE is ignored.
//    i_stop has priority over every same-cycle event (mem_ack, done, finish ack).
//  - reset mid-operation: immediate return to reset values at the next edge.
//  - i_cmd_req while busy: not acked until the FSM is back in IDLE.
//  - o_eng_* values hold until the next grant; o_mem_bm reads 0 outside MEM.
// TESTING
//  1 cmd cnt=1, op3 start req, mem_ack after 4 cycles, done after 10 cycles ->
//    cmd_ack@+1; mem_req with bm_op3; eng_start and start_ack[3] together.
//    Then finish_req with idx=3; after ack, back to IDLE with o_busy=0.
//  2 cmd cnt=3, ops 0, 5 and 15 request together -> grant order 0, 5, 15.
//    A second cmd with cnt=2 and ops 0 and 15 -> order 0, 15 (ptr was 0 after wrap).
//  3 cmd cnt=0 -> single cmd_ack; no mem_req or eng_start; IDLE throughout.
//  4 TMO_W=4, mem_ack never asserted -> o_err_tmo=1 after 15 MEM cycles, state IDLE.
//    No start ack. A new cmd clears o_err_tmo.
//  5 i_stop asserted in RUN in the same cycle as i_eng_done -> IDLE next cycle, no finish_req.
//    Also in MEM with a simultaneous mem_ack -> no eng_start.
//  6 In FIN, ack on a non-granted op bit -> finish_req stays high; correct bit releases it.

Source files
------------

// File: rtl/rsp_s1_op_sched_if.sv
// Signal bundle between the rsp_s1 op scheduler (master) and its command, op, L1-bank
// and engine peers (slave).
interface rsp_s1_op_sched_if #(
    parameter int OP_NUM   = 16,
    parameter int BANK_NUM = 8,
    parameter int CMD_W    = 32,
    parameter int START_W  = 32
);
    localparam int IDX_W = (OP_NUM > 1) ? $clog2(OP_NUM) : 1;

    logic                        i_cmd_req;
    logic [CMD_W-1:0]            i_cmd_info;
    logic [7:0]                  i_cmd_cnt;
    logic                        o_cmd_ack;
    logic [OP_NUM-1:0]           i_start_req_op;
    logic [OP_NUM*START_W-1:0]   i_start_info_op;
    logic [OP_NUM*BANK_NUM-1:0]  i_start_bm_op;
    logic [OP_NUM-1:0]           o_start_ack_op;
    logic                        o_mem_req;
    logic [BANK_NUM-1:0]         o_mem_bm;
    logic                        i_mem_ack;
    logic                        o_eng_start;
    logic [CMD_W-1:0]            o_eng_cmd_info;
    logic [START_W-1:0]          o_eng_start_info;
    logic [IDX_W-1:0]            o_eng_op_idx;
    logic                        i_eng_done;
    logic                        o_finish_req;
    logic [IDX_W-1:0]            o_finish_op_idx;
    logic [OP_NUM-1:0]           i_finish_ack_op;
    logic                        i_stop;
    logic                        o_busy;
    logic                        o_err_tmo;

    modport master (
        input  i_cmd_req, i_cmd_info, i_cmd_cnt, i_start_req_op, i_start_info_op,
               i_start_bm_op, i_mem_ack, i_eng_done, i_finish_ack_op, i_stop,
        output o_cmd_ack, o_start_ack_op, o_mem_req, o_mem_bm, o_eng_start,
               o_eng_cmd_info, o_eng_start_info, o_eng_op_idx, o_finish_req,
               o_finish_op_idx, o_busy, o_err_tmo
    );

    modport slave (
        output i_cmd_req, i_cmd_info, i_cmd_cnt, i_start_req_op, i_start_info_op,
               i_start_bm_op, i_mem_ack, i_eng_done, i_finish_ack_op, i_stop,
        input  o_cmd_ack, o_start_ack_op, o_mem_req, o_mem_bm, o_eng_start,
               o_eng_cmd_info, o_eng_start_info, o_eng_op_idx, o_finish_req,
               o_finish_op_idx, o_busy, o_err_tmo
    );
endinterface

// File: rtl/rsp_s1_op_sched.sv
// Command/op scheduler for the rsp_s1 prep engine: accepts a command, round-robins op
// start requests, secures L1 banks, launches the engine and hands back a finish.
module rsp_s1_op_sched #(
    parameter int OP_NUM   = 16,
    parameter int BANK_NUM = 8,
    parameter int CMD_W    = 32,
    parameter int START_W  = 32,
    parameter int TMO_W    = 16
) (
    input logic               clk,
    input logic               reset,
    rsp_s1_op_sched_if.master bus
);
    localparam int IDX_W = (OP_NUM > 1) ? $clog2(OP_NUM) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(OP_NUM - 1);

    typedef enum logic [2:0] {IDLE, ARB, MEM, START, RUN, FIN} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, idx, grant_idx, cand;
    logic                grant_vld;
    logic [7:0]          cmd_cnt, job_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [BANK_NUM-1:0] bm;
    logic [CMD_W-1:0]    cmd_info;
    logic [START_W-1:0]  start_info;
    logic                cmd_ack, err_tmo;
    logic                stop_hit, cmd_take, fin_ack, last_job, tmo_hit;

    // Holding off a second accept while the ack pulse is out keeps a cnt=0 command single-acked.
    assign stop_hit = bus.i_stop && (state != IDLE);
    assign cmd_take = (state == IDLE) && bus.i_cmd_req && !cmd_ack;
    assign fin_ack  = bus.i_finish_ack_op[idx];
    assign last_job = (job_cnt + 8'd1) == cmd_cnt;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < OP_NUM; i++) begin
            cand = IDX_W'((int'(ptr) + i) % OP_NUM);
            if (!grant_vld && bus.i_start_req_op[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_take && (bus.i_cmd_cnt != 8'd0)) state_nxt = ARB;
            ARB:     if (grant_vld) state_nxt = MEM;
            MEM: begin
                if (bus.i_mem_ack)  state_nxt = START;
                else if (tmo_hit)   state_nxt = IDLE;
            end
            START:   state_nxt = RUN;
            RUN:     if (bus.i_eng_done) state_nxt = FIN;
            FIN:     if (fin_ack) state_nxt = last_job ? IDLE : ARB;
            default: state_nxt = IDLE;
        endcase
        if (stop_hit) state_nxt = IDLE;
    end

    // The ack given in START has already gone out, so ptr advances even on a same-cycle stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ack    <= 1'b0;
            cmd_info   <= '0;
            cmd_cnt    <= '0;
            job_cnt    <= '0;
            err_tmo    <= 1'b0;
            idx        <= '0;
            start_info <= '0;
            bm         <= '0;
            tmo_cnt    <= '0;
            ptr        <= '0;
        end else begin
            cmd_ack <= 1'b0;
            case (state)
                IDLE: if (cmd_take) begin
                    cmd_ack  <= 1'b1;
                    cmd_info <= bus.i_cmd_info;
                    cmd_cnt  <= bus.i_cmd_cnt;
                    job_cnt  <= '0;
                    err_tmo  <= 1'b0;
                end
                ARB: if (grant_vld && !stop_hit) begin
                    idx        <= grant_idx;
                    start_info <= bus.i_start_info_op[grant_idx*START_W +: START_W];
                    bm         <= bus.i_start_bm_op[grant_idx*BANK_NUM +: BANK_NUM];
                    tmo_cnt    <= '0;
                end
                MEM: if (!stop_hit && !bus.i_mem_ack) begin
                    if (tmo_hit) err_tmo <= 1'b1;
                    else         tmo_cnt <= tmo_cnt + 1'b1;
                end
                START: ptr <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                FIN: if (fin_ack && !stop_hit) job_cnt <= job_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign bus.o_cmd_ack        = cmd_ack;
    assign bus.o_mem_req        = (state == MEM);
    assign bus.o_mem_bm         = (state == MEM) ? bm : '0;
    assign bus.o_eng_start      = (state == START);
    assign bus.o_start_ack_op   = (state == START) ? ({{(OP_NUM-1){1'b0}}, 1'b1} << idx) : '0;
    assign bus.o_eng_cmd_info   = cmd_info;
    assign bus.o_eng_start_info = start_info;
    assign bus.o_eng_op_idx     = idx;
    assign bus.o_finish_req     = (state == FIN);
    assign bus.o_finish_op_idx  = (state == FIN) ? idx : '0;
    assign bus.o_busy           = (state != IDLE);
    assign bus.o_err_tmo        = err_tmo;
endmodule

// File: tb/tb_rsp_s1_op_sched.sv
// Self-checking bench for rsp_s1_op_sched: directed scenarios plus randomized commands,
// checked against a round-robin reference model of the op requests.
module tb_rsp_s1_op_sched;
    localparam int OP_NUM   = 16;
    localparam int BANK_NUM = 8;
    localparam int CMD_W    = 32;
    localparam int START_W  = 32;
    localparam int TMO_W    = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [START_W-1:0]  op_info [OP_NUM];
    logic [BANK_NUM-1:0] op_bm   [OP_NUM];
    logic [OP_NUM-1:0]   pending_m;
    logic [CMD_W-1:0]    cmd_info_m;
    int                  ptr_m;

    rsp_s1_op_sched_if #(.OP_NUM(OP_NUM), .BANK_NUM(BANK_NUM), .CMD_W(CMD_W),
                         .START_W(START_W)) bus ();

    rsp_s1_op_sched #(.OP_NUM(OP_NUM), .BANK_NUM(BANK_NUM), .CMD_W(CMD_W),
                      .START_W(START_W), .TMO_W(TMO_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest requesting index at or above the pointer, else wrap to the lowest overall.
    function automatic int model_grant(input logic [OP_NUM-1:0] mask, input int p);
        for (int k = p; k < OP_NUM; k++) if (mask[k]) return k;
        for (int k = 0; k < p; k++) if (mask[k]) return k;
        return 0;
    endfunction

    task automatic setReq(input logic [OP_NUM-1:0] mask);
        pending_m = mask;
        bus.i_start_req_op = mask;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        bus.i_cmd_req = 1'b0;
        bus.i_cmd_info = '0;
        bus.i_cmd_cnt = '0;
        bus.i_mem_ack = 1'b0;
        bus.i_eng_done = 1'b0;
        bus.i_finish_ack_op = '0;
        bus.i_stop = 1'b0;
        setReq('0);
        tick();
        tick();
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] cnt);
        cmd_info_m = $urandom;
        bus.i_cmd_info = cmd_info_m;
        bus.i_cmd_cnt = cnt;
        bus.i_cmd_req = 1'b1;
        tick();
        checkOutput("cmd_ack", bus.o_cmd_ack, 1);
        checkOutput("cmd_info", bus.o_eng_cmd_info, cmd_info_m);
        checkOutput("err_clear", bus.o_err_tmo, 0);
        bus.i_cmd_req = 1'b0;
    endtask

    // stop_mode: 0 none, 1 stop with mem ack on last job, 2 stop with done on last job.
    task automatic serveJobs(input int cnt, input int stop_mode, input bit wrong_ack,
                             input int mem_dly, input int done_dly);
        for (int j = 0; j < cnt; j++) begin
            int exp_idx, n, dm, dd, other;
            exp_idx = model_grant(pending_m, ptr_m);
            n = 0;
            while (!bus.o_mem_req && n < 10) begin
                tick();
                n++;
            end
            checkOutput("mem_req_rise", bus.o_mem_req, 1);
            if (!bus.o_mem_req) return;
            checkOutput("grant_idx", bus.o_eng_op_idx, exp_idx);
            checkOutput("mem_bm", bus.o_mem_bm, op_bm[exp_idx]);
            checkOutput("start_info", bus.o_eng_start_info, op_info[exp_idx]);
            dm = (mem_dly < 0) ? int'($urandom_range(0, 4)) : mem_dly;
            repeat (dm) begin
                tick();
                checkOutput("mem_req_hold", bus.o_mem_req, 1);
            end
            if (stop_mode == 1 && j == cnt - 1) begin
                bus.i_mem_ack = 1'b1;
                bus.i_stop = 1'b1;
                tick();
                bus.i_mem_ack = 1'b0;
                bus.i_stop = 1'b0;
                checkOutput("stop_mem_busy", bus.o_busy, 0);
                checkOutput("stop_mem_start", bus.o_eng_start, 0);
                checkOutput("stop_mem_ack", bus.o_start_ack_op, 0);
                checkOutput("stop_mem_req", bus.o_mem_req, 0);
                return;
            end
            bus.i_mem_ack = 1'b1;
            tick();
            bus.i_mem_ack = 1'b0;
            checkOutput("eng_start", bus.o_eng_start, 1);
            checkOutput("start_ack", bus.o_start_ack_op, 64'(1) << exp_idx);
            checkOutput("mem_req_drop", bus.o_mem_req, 0);
            checkOutput("mem_bm_idle", bus.o_mem_bm, 0);
            pending_m[exp_idx] = 1'b0;
            bus.i_start_req_op = pending_m;
            ptr_m = (exp_idx + 1) % OP_NUM;
            tick();
            checkOutput("eng_start_pulse", bus.o_eng_start, 0);
            dd = (done_dly < 1) ? int'($urandom_range(1, 8)) : done_dly;
            repeat (dd - 1) tick();
            checkOutput("run_no_finish", bus.o_finish_req, 0);
            if (stop_mode == 2 && j == cnt - 1) begin
                bus.i_eng_done = 1'b1;
                bus.i_stop = 1'b1;
                tick();
                bus.i_eng_done = 1'b0;
                bus.i_stop = 1'b0;
                checkOutput("stop_run_busy", bus.o_busy, 0);
                checkOutput("stop_run_fin", bus.o_finish_req, 0);
                return;
            end
            bus.i_eng_done = 1'b1;
            tick();
            bus.i_eng_done = 1'b0;
            checkOutput("finish_req", bus.o_finish_req, 1);
            checkOutput("finish_idx", bus.o_finish_op_idx, exp_idx);
            if (wrong_ack) begin
                other = (exp_idx + int'($urandom_range(1, OP_NUM - 1))) % OP_NUM;
                bus.i_finish_ack_op = OP_NUM'(1) << other;
                tick();
                bus.i_finish_ack_op = '0;
                checkOutput("finish_wrong_ack", bus.o_finish_req, 1);
            end
            bus.i_finish_ack_op = OP_NUM'(1) << exp_idx;
            tick();
            bus.i_finish_ack_op = '0;
            checkOutput("finish_drop", bus.o_finish_req, 0);
            checkOutput("busy_after_fin", bus.o_busy, (j != cnt - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int n, mem_cycles, seen, sa_seen, op, cnt;
        logic [OP_NUM-1:0] mask;

        for (int i = 0; i < OP_NUM; i++) begin
            op_info[i] = $urandom;
            op_bm[i]   = BANK_NUM'($urandom);
            bus.i_start_info_op[i*START_W +: START_W] = op_info[i];
            bus.i_start_bm_op[i*BANK_NUM +: BANK_NUM] = op_bm[i];
        end
        resetDut();
        checkOutput("rst_busy", bus.o_busy, 0);
        checkOutput("rst_cmd_ack", bus.o_cmd_ack, 0);
        checkOutput("rst_mem_req", bus.o_mem_req, 0);
        checkOutput("rst_eng_start", bus.o_eng_start, 0);
        checkOutput("rst_start_ack", bus.o_start_ack_op, 0);
        checkOutput("rst_finish_req", bus.o_finish_req, 0);
        checkOutput("rst_err", bus.o_err_tmo, 0);
        checkOutput("rst_op_idx", bus.o_eng_op_idx, 0);
        checkOutput("rst_cmd_info", bus.o_eng_cmd_info, 0);

        $display("[TB] single job on op3");
        setReq(OP_NUM'(1) << 3);
        applyStimulus(8'd1);
        serveJobs(1, 0, 1'b0, 4, 10);

        $display("[TB] round robin ordering");
        resetDut();
        setReq((OP_NUM'(1) << 0) | (OP_NUM'(1) << 5) | (OP_NUM'(1) << 15));
        applyStimulus(8'd3);
        serveJobs(3, 0, 1'b0, -1, -1);
        setReq((OP_NUM'(1) << 0) | (OP_NUM'(1) << 15));
        applyStimulus(8'd2);
        serveJobs(2, 0, 1'b0, -1, -1);

        $display("[TB] zero-count command");
        setReq(OP_NUM'(1) << 7);
        applyStimulus(8'd0);
        tick();
        checkOutput("cnt0_single_ack", bus.o_cmd_ack, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("cnt0_idle", bus.o_busy, 0);
            checkOutput("cnt0_no_mem", bus.o_mem_req, 0);
        end
        setReq('0);

        $display("[TB] mem ack timeout");
        op = int'($urandom_range(0, OP_NUM - 1));
        setReq(OP_NUM'(1) << op);
        applyStimulus(8'd1);
        mem_cycles = 0;
        seen = 0;
        sa_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.o_start_ack_op != '0) sa_seen = 1;
            if (bus.o_mem_req) begin
                mem_cycles++;
                seen = 1;
            end else if (seen != 0) begin
                break;
            end
        end
        checkOutput("tmo_mem_cycles", mem_cycles, (2 ** TMO_W) - 1);
        checkOutput("tmo_err", bus.o_err_tmo, 1);
        checkOutput("tmo_idle", bus.o_busy, 0);
        checkOutput("tmo_no_start_ack", sa_seen, 0);
        tick();
        checkOutput("tmo_err_sticky", bus.o_err_tmo, 1);
        applyStimulus(8'd1);
        serveJobs(1, 0, 1'b1, -1, -1);

        $display("[TB] stop during RUN and MEM");
        setReq(OP_NUM'(1) << $urandom_range(0, OP_NUM - 1));
        applyStimulus(8'd1);
        serveJobs(1, 2, 1'b0, -1, -1);
        setReq(OP_NUM'(1) << $urandom_range(0, OP_NUM - 1));
        applyStimulus(8'd1);
        serveJobs(1, 1, 1'b0, -1, -1);
        setReq('0);

        $display("[TB] reset mid-operation");
        setReq(OP_NUM'(1) << $urandom_range(0, OP_NUM - 1));
        applyStimulus(8'd1);
        n = 0;
        while (!bus.o_mem_req && n < 10) begin
            tick();
            n++;
        end
        checkOutput("mid_mem_req", bus.o_mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr_m = 0;
        checkOutput("mid_rst_busy", bus.o_busy, 0);
        checkOutput("mid_rst_mem_req", bus.o_mem_req, 0);
        checkOutput("mid_rst_op_idx", bus.o_eng_op_idx, 0);
        checkOutput("mid_rst_cmd_info", bus.o_eng_cmd_info, 0);
        setReq(pending_m | (OP_NUM'(1) << $urandom_range(0, OP_NUM - 1)));
        applyStimulus(8'd1);
        serveJobs(1, 0, 1'b0, -1, -1);
        setReq('0);

        $display("[TB] randomized commands");
        for (int it = 0; it < 6; it++) begin
            mask = OP_NUM'($urandom);
            if (mask == '0) mask = OP_NUM'(1);
            cnt = int'($urandom_range(1, 4));
            if (cnt > $countones(mask)) cnt = $countones(mask);
            setReq(mask);
            applyStimulus(8'(cnt));
            serveJobs(cnt, 0, 1'($urandom_range(0, 1)), -1, -1);
            setReq('0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
